regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Owns the single write port of the 32x32 register file. Shares it between two
//  writeback requesters (A = ALU, B = load/MEM) with round-robin arbitration
//  over valid/ready handshakes. After reset it runs an init sweep that loads
//  reg[i] = i, so the register file needs no combinational reset of its own.
//  Sits between the writeback stage and the register file's RegWrite/write_reg/write_data.
// PARAMETERS
//  NUM_REGS  32  registers in the file; init sweep length
//  AW        5   register address width, clog2(NUM_REGS)
//  DW        32  data width
//  INIT_EN   1   1 = run init sweep after reset; 0 = go straight to RUN
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   asynchronous, active-low reset
//  a_valid     in   1   requester A has a write pending
//  a_ready     out  1   A accepted this cycle (combinational)
//  a_reg       in   AW  A destination register
//  a_data      in   DW  A write data
//  b_valid     in   1   requester B has a write pending
//  b_ready     out  1   B accepted this cycle (combinational)
//  b_reg       in   AW  B destination register
//  b_data      in   DW  B write data
//  RegWrite    out  1   register-file write enable (registered)
//  write_reg   out  AW  register-file write address (registered)
//  write_data  out  DW  register-file write data (registered)
//  init_done   out  1   1 once the init sweep is complete (registered, sticky)
// BEHAVIOUR
//  Reset (rst=0, async): state=INIT (RUN if INIT_EN=0), cnt=0, last_grant=B,
//   RegWrite=0, write_reg=0, write_data=0, init_done=INIT_EN?0:1; a_ready=b_ready=0.
//  FSM INIT: a_ready=b_ready=0. Each edge: RegWrite<=1, write_reg<=cnt,
//   write_data<=zero-extended cnt, cnt<=cnt+1. On the edge where cnt==NUM_REGS-1:
//   state<=RUN, init_done<=1. The sweep writes reg0 (value 0). Exactly NUM_REGS
//   write cycles are issued, with no gaps.
//  FSM RUN (terminal until reset):
//   Grant is combinational. Only A valid -> A. Only B valid -> B.
//   Both valid -> the requester != last_grant.
//   x_ready = grant_x; transfer = x_valid & x_ready; last_grant <= x on transfer.
//   Next edge after a transfer: RegWrite <= (x_reg != 0), write_reg <= x_reg,
//   write_data <= x_data. A write to r0 is consumed, but RegWrite stays 0, so r0 stays 0.
//   No transfer -> RegWrite<=0; write_reg/write_data hold their last value.
//  Latency: accept edge -> RegWrite high for exactly 1 cycle after it.
//  Throughput: 1 write/cycle; a continuous single requester is never stalled.
//  Both valid with the same destination: writes are serialized in grant order,
//   so the last granted write wins.
//  Requesters hold valid/reg/data stable until ready. The arbiter does not
//   require this but grants whatever is presented.
//  Reset mid-INIT or mid-RUN: in-flight write is dropped, RegWrite=0
//   immediately, and the sweep restarts at cnt=0.
// TESTING
//  1 Release rst, no requests -> RegWrite=1 for 32 consecutive cycles,
//    write_reg=write_data=0..31; init_done=1 after 32nd edge; a/b_ready=0 meanwhile.
//  2 RUN, a_valid=1 a_reg=5 a_data=0xDEADBEEF for 1 cycle -> a_ready=1 that cycle;
//    next cycle RegWrite=1, write_reg=5, write_data=0xDEADBEEF; then RegWrite=0.
//  3 RUN, a_valid=b_valid=1 held 4 cycles (a_reg=3, b_reg=4) -> grants A,B,A,B;
//    RegWrite high 4 cycles with write_reg=3,4,3,4.
//  4 b_valid=1 b_reg=0 b_data=0x55 -> b_ready=1; RegWrite stays 0 the next cycle.
//  5 b_valid=1 for 8 cycles, regs 1..8, a_valid=0 -> b_ready=1 every cycle;
//    8 back-to-back writes in order.
//  6 Assert rst on sweep cycle 10, release 2 cycles later -> RegWrite=0 during
//    reset; sweep restarts at write_reg=0 and runs 32 cycles; init_done=0 until then.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-port owner for the 32x32 register file: init sweep (reg[i]=i) after reset,
// then round-robin arbitration between ALU (A) and load (B) writeback requesters.
module regfile_wb_arbiter #(
  parameter int NUM_REGS = 32,
  parameter int AW       = 5,
  parameter int DW       = 32,
  parameter bit INIT_EN  = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_reg,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_reg,
  input  logic [DW-1:0] b_data,
  output logic          RegWrite,
  output logic [AW-1:0] write_reg,
  output logic [DW-1:0] write_data,
  output logic          init_done
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  localparam state_t        RST_STATE = INIT_EN ? S_INIT : S_RUN;
  localparam logic [AW-1:0] CNT_LAST  = AW'(NUM_REGS - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] cnt;
  logic          last_b;      // 1: most recent transfer went to B
  logic          sweep_last;
  logic          a_xfer, b_xfer;

  assign sweep_last = (cnt == CNT_LAST);
  assign a_xfer     = a_valid & a_ready;
  assign b_xfer     = b_valid & b_ready;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RST_STATE;
    else      state <= state_nxt;
  end

  // Next-state logic; RUN is terminal until reset
  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:  if (sweep_last) state_nxt = S_RUN;
      S_RUN:   state_nxt = S_RUN;
      default: state_nxt = RST_STATE;
    endcase
  end

  // Output logic: combinational grant, the non-last requester wins a tie
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (state == S_RUN) begin
      a_ready = a_valid & (~b_valid | last_b);
      b_ready = b_valid & (~a_valid | ~last_b);
    end
  end

  // Registered write port, sweep counter and fairness pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      last_b     <= 1'b1;
      RegWrite   <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
      init_done  <= ~INIT_EN;
    end else if (state == S_INIT) begin
      RegWrite   <= 1'b1;
      write_reg  <= cnt;
      write_data <= DW'(cnt);
      cnt        <= cnt + 1'b1;
      if (sweep_last) init_done <= 1'b1;
    end else if (a_xfer) begin
      // r0 writes are consumed but never enabled, keeping r0 at zero
      RegWrite   <= (a_reg != '0);
      write_reg  <= a_reg;
      write_data <= a_data;
      last_b     <= 1'b0;
    end else if (b_xfer) begin
      RegWrite   <= (b_reg != '0);
      write_reg  <= b_reg;
      write_data <= b_data;
      last_b     <= 1'b1;
    end else begin
      RegWrite   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: init sweep, single writes, round robin,
// r0 suppression, back-to-back streaming and reset in the middle of the sweep.
module tb_regfile_wb_arbiter;

  logic        clk, rst;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [4:0]  a_reg, b_reg, write_reg;
  logic [31:0] a_data, b_data, write_data;
  logic        RegWrite, init_done;
  int          checks, failures;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .RegWrite(RegWrite), .write_reg(write_reg), .write_data(write_data),
    .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs the 32-write sweep from the first edge after reset release
  task automatic run_sweep(input string tag);
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      checks++;
      if (RegWrite !== 1'b1 || write_reg !== 5'(i) || write_data !== 32'(i)) begin
        failures++;
        $display("FAIL %s_sweep[%0d] got we=%b reg=%0d data=%0h want we=1 reg=%0d data=%0h",
                 tag, i, RegWrite, write_reg, write_data, i, i);
      end
      checks++;
      if (init_done !== (i == 31)) begin
        failures++;
        $display("FAIL %s_init_done[%0d] got %b want %b", tag, i, init_done, i == 31);
      end
      if (i < 31) begin
        checks++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
          failures++;
          $display("FAIL %s_ready_in_init[%0d] got a=%b b=%b want 0 0", tag, i, a_ready, b_ready);
        end
      end
    end
  endtask

  task automatic test_reset_sweep();
    rst = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
    a_reg = 5'd7; b_reg = 5'd9; a_data = 32'h1111; b_data = 32'h2222;
    #3;
    checks++;
    if (RegWrite !== 1'b0 || write_reg !== 5'd0 || write_data !== 32'd0 || init_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got we=%b reg=%0d data=%0h done=%b want 0 0 0 0",
               RegWrite, write_reg, write_data, init_done);
    end
    checks++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready got a=%b b=%b want 0 0", a_ready, b_ready);
    end
    @(negedge clk); rst = 1'b1;
    run_sweep("first");
    a_valid = 1'b0; b_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (RegWrite !== 1'b0 || init_done !== 1'b1) begin
      failures++;
      $display("FAIL after_sweep got we=%b done=%b want we=0 done=1", RegWrite, init_done);
    end
  endtask

  task automatic test_single_a();
    @(negedge clk);
    a_valid = 1'b1; a_reg = 5'd5; a_data = 32'hDEADBEEF;
    #1;
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      failures++;
      $display("FAIL single_a_ready got a=%b b=%b want 1 0", a_ready, b_ready);
    end
    @(posedge clk); #1;
    a_valid = 1'b0;
    checks++;
    if (RegWrite !== 1'b1 || write_reg !== 5'd5 || write_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL single_a_write got we=%b reg=%0d data=%0h want 1 5 deadbeef",
               RegWrite, write_reg, write_data);
    end
    @(posedge clk); #1;
    checks++;
    if (RegWrite !== 1'b0 || write_reg !== 5'd5 || write_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL single_a_idle got we=%b reg=%0d data=%0h want 0 5 deadbeef (held)",
               RegWrite, write_reg, write_data);
    end
  endtask

  // Leaves last grant at B so the round-robin test starts with A
  task automatic test_r0_write();
    @(negedge clk);
    b_valid = 1'b1; b_reg = 5'd0; b_data = 32'h55;
    #1;
    checks++;
    if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
      failures++;
      $display("FAIL r0_ready got a=%b b=%b want 0 1", a_ready, b_ready);
    end
    @(posedge clk); #1;
    b_valid = 1'b0;
    checks++;
    if (RegWrite !== 1'b0 || write_reg !== 5'd0 || write_data !== 32'h55) begin
      failures++;
      $display("FAIL r0_write got we=%b reg=%0d data=%0h want 0 0 55", RegWrite, write_reg, write_data);
    end
  endtask

  task automatic test_round_robin();
    @(negedge clk);
    a_valid = 1'b1; a_reg = 5'd3; a_data = 32'hA0A0;
    b_valid = 1'b1; b_reg = 5'd4; b_data = 32'hB0B0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (a_ready !== (k % 2 == 0) || b_ready !== (k % 2 == 1)) begin
        failures++;
        $display("FAIL rr_grant[%0d] got a=%b b=%b want a=%b b=%b",
                 k, a_ready, b_ready, k % 2 == 0, k % 2 == 1);
      end
      @(posedge clk); #1;
      checks++;
      if (RegWrite !== 1'b1 || write_reg !== ((k % 2 == 0) ? 5'd3 : 5'd4) ||
          write_data !== ((k % 2 == 0) ? 32'hA0A0 : 32'hB0B0)) begin
        failures++;
        $display("FAIL rr_write[%0d] got we=%b reg=%0d data=%0h want we=1 reg=%0d",
                 k, RegWrite, write_reg, write_data, (k % 2 == 0) ? 3 : 4);
      end
    end
    a_valid = 1'b0; b_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (RegWrite !== 1'b0) begin
      failures++;
      $display("FAIL rr_idle got we=%b want 0", RegWrite);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    b_valid = 1'b1; b_reg = 5'd1; b_data = 32'h101;
    for (int i = 1; i <= 8; i++) begin
      #1;
      checks++;
      if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
        failures++;
        $display("FAIL b2b_ready[%0d] got a=%b b=%b want 0 1", i, a_ready, b_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (RegWrite !== 1'b1 || write_reg !== 5'(i) || write_data !== 32'h100 + 32'(i)) begin
        failures++;
        $display("FAIL b2b_write[%0d] got we=%b reg=%0d data=%0h want 1 %0d %0h",
                 i, RegWrite, write_reg, write_data, i, 32'h100 + 32'(i));
      end
      b_reg = 5'(i + 1); b_data = 32'h100 + 32'(i + 1);
    end
    b_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (RegWrite !== 1'b0 || write_reg !== 5'd8) begin
      failures++;
      $display("FAIL b2b_idle got we=%b reg=%0d want 0 8", RegWrite, write_reg);
    end
  endtask

  task automatic test_reset_mid_sweep();
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    repeat (10) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (RegWrite !== 1'b0 || init_done !== 1'b0 || write_reg !== 5'd0) begin
      failures++;
      $display("FAIL mid_reset got we=%b done=%b reg=%0d want 0 0 0", RegWrite, init_done, write_reg);
    end
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (RegWrite !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_hold got we=%b want 0", RegWrite);
    end
    @(negedge clk); rst = 1'b1;
    run_sweep("restart");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; failures = 0;
    a_valid = 1'b0; b_valid = 1'b0;
    a_reg = '0; b_reg = '0; a_data = '0; b_data = '0;
    test_reset_sweep();
    test_single_a();
    test_r0_write();
    test_round_robin();
    test_back_to_back();
    test_reset_mid_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
